// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and constants for the two-master Wishbone memory arbiter.
package wb_arb_pkg;
    typedef enum logic [1:0] {IDLE, GNT0, GNT1, ERR} state_t;
    localparam int IMEM_M = 0;
    localparam int DMEM_M = 1;
    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;
endpackage

// File: rtl/wb_arb_timeout.sv
// wb_arb_timeout: slave-stall counter; expired flags the last stalled cycle before a bus error.
module wb_arb_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic count_en,
    input  logic clr,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (count_en) cnt <= cnt + CW'(1);
    end
    // Qualified by count_en so an ack in the final cycle suppresses the error.
    assign expired = count_en && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: round-robin arbiter giving an instruction and a data master
// shared access to one Wishbone slave, with a stall timeout that raises a bus error.
module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            m_cyc_i,
    input  logic [1:0]            m_stb_i,
    input  logic [1:0]            m_we_i,
    input  logic [2*AW-1:0]       m_adr_i,
    input  logic [2*DW-1:0]       m_dat_i,
    input  logic [2*(DW/8)-1:0]   m_sel_i,
    output logic [DW-1:0]         m_dat_o,
    output logic [1:0]            m_ack_o,
    output logic [1:0]            m_err_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [AW-1:0]         s_adr_o,
    output logic [DW-1:0]         s_dat_o,
    output logic [DW/8-1:0]       s_sel_o,
    input  logic [DW-1:0]         s_dat_i,
    input  logic                  s_ack_i,
    output logic [1:0]            gnt_o
);
    localparam int SW = DW / 8;
    state_t state, nxt;
    logic last_gnt, nxt_last, owner, in_gnt, expired, stall;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state    <= nxt;
            last_gnt <= nxt_last;
        end
    end
    always_comb begin
        in_gnt = (state == GNT0) || (state == GNT1);
        owner  = (state == GNT1) || ((state == ERR) && last_gnt);
        nxt      = state;
        nxt_last = last_gnt;
        unique case (state)
            IDLE: if (m_cyc_i != 2'b00) begin
                nxt_last = (&m_cyc_i) ? ~last_gnt : m_cyc_i[DMEM_M];
                nxt      = nxt_last ? GNT1 : GNT0;
            end
            GNT0, GNT1: nxt = !m_cyc_i[owner] ? IDLE : expired ? ERR : state;
            ERR:        nxt = !m_cyc_i[owner] ? IDLE : owner ? GNT1 : GNT0;
            default:    nxt = IDLE;
        endcase
    end
    assign s_cyc_o = in_gnt && m_cyc_i[owner];
    assign s_stb_o = in_gnt && m_stb_i[owner];
    assign s_we_o  = in_gnt && m_we_i[owner];
    assign s_adr_o = !in_gnt ? '0 : owner ? m_adr_i[2*AW-1:AW] : m_adr_i[AW-1:0];
    assign s_dat_o = !in_gnt ? '0 : owner ? m_dat_i[2*DW-1:DW] : m_dat_i[DW-1:0];
    assign s_sel_o = !in_gnt ? '0 : owner ? m_sel_i[2*SW-1:SW] : m_sel_i[SW-1:0];
    assign m_dat_o = s_dat_i;
    assign m_ack_o = {in_gnt && owner && s_ack_i, in_gnt && !owner && s_ack_i};
    assign gnt_o   = (in_gnt || state == ERR) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign m_err_o = (state == ERR) ? gnt_o : 2'b00;
    assign stall   = s_stb_o && !s_ack_i;
    wb_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .count_en(stall),
        .clr     (!in_gnt || s_ack_i),
        .expired (expired)
    );
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb_wb_mem_arbiter: directed checks of grant, round-robin, burst hold, timeout and reset.
module tb_wb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  m_cyc, m_stb, m_we, m_ack, m_err, gnt;
    logic [63:0] m_adr, m_dat;
    logic [7:0]  m_sel;
    logic [31:0] m_rdat, s_adr, s_wdat, s_rdat;
    logic [3:0]  s_sel;
    logic        s_cyc, s_stb, s_we, s_ack;
    int vectors = 0;
    int miscompares = 0;

    wb_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_dat_o(m_rdat), .m_ack_o(m_ack), .m_err_o(m_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel),
        .s_dat_i(s_rdat), .s_ack_i(s_ack), .gnt_o(gnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset_n = 1'b0; m_cyc = 0; m_stb = 0; m_we = 0; m_adr = 0; m_dat = 0; m_sel = 0;
        s_rdat = 0; s_ack = 0;
        #3;
        chk("rst_gnt", gnt, 0); chk("rst_scyc", s_cyc, 0); chk("rst_ack", m_ack, 0); chk("rst_err", m_err, 0);
        step(); step();
        reset_n = 1'b1;
        // single request from m0, ack on its second granted cycle
        step(); m_cyc = 2'b01; m_stb = 2'b01; m_adr = 64'h0000_0000_0000_0010; #1;
        chk("s1_idle_gnt", gnt, 0); chk("s1_idle_scyc", s_cyc, 0);
        step(); #1;
        chk("s1_gnt", gnt, 2'b01); chk("s1_scyc", s_cyc, 1); chk("s1_sstb", s_stb, 1);
        chk("s1_adr", s_adr, 32'h10); chk("s1_noack", m_ack, 0);
        step(); s_ack = 1; #1;
        chk("s1_ack", m_ack, 2'b01); chk("s1_adr2", s_adr, 32'h10);
        step(); s_ack = 0; m_cyc = 0; m_stb = 0; #1;
        chk("s1_ack_done", m_ack, 0); chk("s1_scyc_drop", s_cyc, 0);
        step(); #1;
        chk("s1_idle", gnt, 0); chk("s1_idle_adr", s_adr, 0);
        // reset, then simultaneous requests
        reset_n = 1'b0; #1; reset_n = 1'b1;
        step(); m_cyc = 2'b11; m_stb = 2'b11; m_adr = 64'h0000_0200_0000_0100; #1;
        chk("rr_idle", gnt, 0);
        step(); s_ack = 1; s_rdat = 32'hCAFE_0001; #1;
        chk("rr_gnt0", gnt, 2'b01); chk("rr_adr0", s_adr, 32'h100); chk("rr_ack0", m_ack, 2'b01);
        chk("rr_rdat", m_rdat, 32'hCAFE_0001);
        step(); s_ack = 0; m_cyc = 2'b10; m_stb = 2'b10; #1;
        chk("rr_hold0", gnt, 2'b01); chk("rr_scyc_drop", s_cyc, 0);
        step(); #1;
        chk("rr_gap", gnt, 0);
        step(); s_ack = 1; #1;
        chk("rr_gnt1", gnt, 2'b10); chk("rr_adr1", s_adr, 32'h200); chk("rr_ack1", m_ack, 2'b10);
        step(); s_ack = 0; m_cyc = 0; m_stb = 0; #1;
        step(); m_cyc = 2'b11; m_stb = 2'b11; #1;
        chk("rr_gap2", gnt, 0);
        step(); #1;
        chk("rr_regrant0", gnt, 2'b01);
        step(); m_cyc = 0; m_stb = 0; #1;
        // burst hold: m1 four beats, m0 joins at beat 2
        step(); m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10;
        m_dat = 64'hDEAD_BEEF_0000_0000; m_sel = 8'hA0; m_adr = 64'h0000_0300_0000_0000; #1;
        for (int b = 1; b <= 4; b++) begin
            step(); s_ack = 1;
            if (b >= 2) begin m_cyc = 2'b11; m_stb = 2'b11; end
            #1;
            chk("bh_gnt", gnt, 2'b10); chk("bh_ack", m_ack, 2'b10);
        end
        chk("bh_we", s_we, 1); chk("bh_dat", s_wdat, 32'hDEAD_BEEF); chk("bh_sel", s_sel, 4'hA);
        chk("bh_adr", s_adr, 32'h300);
        step(); s_ack = 0; m_cyc = 2'b01; m_stb = 2'b01; m_we = 0; #1;
        chk("bh_tail", gnt, 2'b10); chk("bh_tail_ack", m_ack, 0);
        step(); #1;
        chk("bh_gap", gnt, 0);
        step(); s_ack = 1; #1;
        chk("bh_gnt0", gnt, 2'b01); chk("bh_ack0", m_ack, 2'b01);
        step(); s_ack = 0; m_cyc = 0; m_stb = 0; #1;
        // timeout: slave never acks m0
        step(); m_cyc = 2'b01; m_stb = 2'b01; #1;
        for (int c = 0; c < 4; c++) begin
            step(); #1;
            chk("to_stall_err", m_err, 0); chk("to_stall_stb", s_stb, 1);
        end
        step(); #1;
        chk("to_err", m_err, 2'b01); chk("to_err_stb", s_stb, 0); chk("to_err_cyc", s_cyc, 0);
        chk("to_err_gnt", gnt, 2'b01); chk("to_err_ack", m_ack, 0);
        step(); #1;
        chk("to_regrant", gnt, 2'b01); chk("to_regrant_err", m_err, 0); chk("to_regrant_stb", s_stb, 1);
        step(); m_cyc = 0; m_stb = 0; #1;
        // ack on the fourth stall cycle beats the timeout
        step(); m_cyc = 2'b10; m_stb = 2'b10; #1;
        step(); step(); step(); #1;
        chk("race_pre_err", m_err, 0);
        step(); s_ack = 1; #1;
        chk("race_ack", m_ack, 2'b10); chk("race_err", m_err, 0);
        step(); s_ack = 0; #1;
        chk("race_after_err", m_err, 0); chk("race_after_gnt", gnt, 2'b10);
        // mid-transfer reset while m1 is stalled
        step(); m_cyc = 2'b11; m_stb = 2'b11; #1;
        reset_n = 1'b0; #1;
        chk("mr_gnt", gnt, 0); chk("mr_cyc", s_cyc, 0); chk("mr_stb", s_stb, 0);
        chk("mr_adr", s_adr, 0); chk("mr_ack", m_ack, 0); chk("mr_err", m_err, 0);
        step(); reset_n = 1'b1; #1;
        chk("mr_idle", gnt, 0);
        step(); #1;
        chk("mr_tie_m0", gnt, 2'b01);
        step(); m_cyc = 0; m_stb = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wb_mem_arbiter.md
WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

Interface
REQ-001 Parameter AW, 32: Wishbone address width.
REQ-002 Parameter DW, 32: Wishbone data width; SW = DW/8 byte selects.
REQ-003 Parameter TIMEOUT, 255: slave-stall cycles before bus error; legal range 2..65535.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 m_cyc_i  input  2  per-master cycle request; bit 0 = instruction fetch, bit 1 = data port.
REQ-007 m_stb_i  input  2  per-master strobe.
REQ-008 m_we_i  input  2  per-master write enable.
REQ-009 m_adr_i  input  2xAW  per-master address.
REQ-010 m_dat_i  input  2xDW  per-master write data.
REQ-011 m_sel_i  input  2xSW  per-master byte selects.
REQ-012 m_dat_o  output  DW  slave read data, broadcast to both masters.
REQ-013 m_ack_o  output  2  per-master acknowledge.
REQ-014 m_err_o  output  2  per-master timeout error pulse.
REQ-015 s_cyc_o, s_stb_o, s_we_o  output  1 each  slave control.
REQ-016 s_adr_o  output  AW; s_dat_o  output  DW; s_sel_o  output  SW: slave request fields.
REQ-017 s_dat_i  input  DW; s_ack_i  input  1: slave response.
REQ-018 gnt_o  output  2  one-hot current grant; 00 when idle.

Function
REQ-019 States: IDLE, GNT0, GNT1, ERR. The encoding is an enum.
REQ-020 IDLE: if exactly one m_cyc_i bit is set, the next state shall be the GNT state for that master.
REQ-021 IDLE with both m_cyc_i set: grant the master not in last_gnt (round-robin); last_gnt updates on each grant.
REQ-022 Arbitration latency is one cycle: a request in IDLE at edge N drives s_cyc_o from edge N+1.
REQ-023 GNTx: s_cyc/stb/we/adr/dat/sel are combinationally muxed from master x; m_ack_o[x] = s_ack_i; the other master's ack and err are 0.
REQ-024 Idle slave outputs are s_cyc_o = s_stb_o = s_we_o = 0; adr, dat, sel are 0.
REQ-025 Grant persists while m_cyc_i[x] = 1, across multiple stb/ack beats, with no re-arbitration.
REQ-026 GNTx with m_cyc_i[x] = 0 returns to IDLE on the next edge; at least one IDLE cycle separates grants.
REQ-027 Stall counter (width ceil(log2(TIMEOUT+1))) increments each GNT cycle with s_stb_o = 1 and s_ack_i = 0, and clears on ack or on leaving GNT.
REQ-028 If the counter reaches TIMEOUT-1 without an ack, the next state is ERR.
REQ-029 ERR lasts exactly one cycle: m_err_o[x] = 1, s_cyc_o = s_stb_o = 0, and the counter clears.
REQ-030 After ERR: return to GNTx if m_cyc_i[x] is still 1, else IDLE.
REQ-031 An ack arriving in the same cycle the counter reaches TIMEOUT-1 wins: no error, counter clears.
REQ-032 s_ack_i in IDLE or ERR is ignored; it is never forwarded.
REQ-033 gnt_o = 01 in GNT0/ERR-from-0, 10 in GNT1/ERR-from-1, 00 in IDLE.

Reset
REQ-034 Asserting reset_n low shall force, immediately and mid-transfer, state = IDLE, counter = 0, last_gnt = 1 (master 0 wins the first tie), and all outputs to their REQ-024 idle values with acks, errs and gnt_o = 0.
REQ-035 After reset_n deasserts, the first arbitration decision occurs on the first rising edge.

Structure
REQ-036 A shared package wb_arb_pkg shall hold the state enum, master index constants (IMEM_M = 0, DMEM_M = 1), and default AW/DW.
REQ-037 One sub-module, wb_arb_timeout, shall hold the stall counter with inputs count_en and clr and output expired; the arbiter FSM and mux stay in the top module.

Verification
REQ-038 Single request: m0 cyc/stb at adr 0x0000_0010, slave acks on the 2nd cycle -> s_adr_o = 0x10 from cycle 1, m_ack_o = 01 one cycle, gnt_o = 01 then 00.
REQ-039 Simultaneous requests after reset: both cyc at the same edge -> m0 granted first; after m0 drops cyc, one IDLE cycle, then m1 granted; then repeat both -> m1 is not granted twice consecutively (m0 first).
REQ-040 Burst hold: m1 holds cyc for 4 beats (acks each), m0 requests at beat 2 -> gnt_o stays 10 through beat 4, m_ack_o[0] never 1 until m0 is granted.
REQ-041 Timeout: TIMEOUT = 4, slave never acks -> m_err_o[granted] = 1 exactly 4 cycles after the first stb cycle; s_stb_o = 0 in that cycle.
REQ-042 Ack/timeout race: TIMEOUT = 4, ack on the 4th stall cycle -> m_ack_o asserted, m_err_o stays 0.
REQ-043 Mid-transfer reset: reset_n low while GNT1 is stalled -> all outputs 0 immediately; after release, a tie grants m0.
